// File: rtl/spike_rate_decoder_if.sv
// Result bus of spike_rate_decoder: windowed spike count plus status flags.
// Latency: n/a (wiring only).
// Backpressure: rate_ready from the consumer; rate/saturated hold while rate_valid && !rate_ready.
interface spike_rate_decoder_if #(
    parameter int COUNT_W = 8
);
    logic [COUNT_W-1:0] rate;
    logic               rate_valid;
    logic               rate_ready;
    logic               saturated;
    logic               overrun;
`ifdef SPIKE_ISI_EN
    logic [COUNT_W-1:0] isi;
`endif

`ifdef SPIKE_ISI_EN
    modport master (
        output rate,
        output rate_valid,
        output saturated,
        output overrun,
        output isi,
        input  rate_ready
    );

    modport slave (
        input  rate,
        input  rate_valid,
        input  saturated,
        input  overrun,
        input  isi,
        output rate_ready
    );
`else
    modport master (
        output rate,
        output rate_valid,
        output saturated,
        output overrun,
        input  rate_ready
    );

    modport slave (
        input  rate,
        input  rate_valid,
        input  saturated,
        input  overrun,
        output rate_ready
    );
`endif
endinterface

// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts spike-high cycles over a window of window_len+1 cycles and publishes the count.
// Latency: result valid on the edge closing the window (window started at edge E ends at E+window_len+1).
// Backpressure: result held until rate_ready; a new window end over an unconsumed result sets sticky overrun.
// Optional inter-spike interval output enabled by defining SPIKE_ISI_EN.
module spike_rate_decoder #(
    parameter int WINDOW_W = 8,
    parameter int COUNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                spike,
    input  logic [WINDOW_W-1:0] window_len,
    spike_rate_decoder_if.master out_if
);

    localparam logic [0:0]         ST_IDLE = 1'b0;
    localparam logic [0:0]         ST_RUN  = 1'b1;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    // Window FSM and counters
    logic [0:0]          state_q;
    logic [WINDOW_W-1:0] win_len_q;
    logic [WINDOW_W-1:0] cyc_cnt_q;
    logic [COUNT_W-1:0]  spk_cnt_q;
    logic                sat_q;

    // Output register
    logic [COUNT_W-1:0]  rate_q;
    logic                rate_valid_q;
    logic                saturated_q;
    logic                overrun_q;

    logic                running;
    logic                win_end;
    logic                handshake;
    logic [COUNT_W-1:0]  spk_cnt_nxt;
    logic                sat_nxt;

    assign running   = (state_q == ST_RUN);
    assign win_end   = running && (cyc_cnt_q == win_len_q);
    assign handshake = rate_valid_q && out_if.rate_ready;

    // Count including this cycle's spike; the counter sticks at its maximum instead of wrapping
    always_comb begin
        spk_cnt_nxt = spk_cnt_q;
        if (spike && (spk_cnt_q != CNT_MAX)) begin
            spk_cnt_nxt = spk_cnt_q + 1'b1;
        end
        sat_nxt = sat_q | (spk_cnt_nxt == CNT_MAX);
    end

    // Window sequencing: start on enable, restart back-to-back at window end, abort when enable drops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            win_len_q <= '0;
            cyc_cnt_q <= '0;
            spk_cnt_q <= '0;
            sat_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cyc_cnt_q <= '0;
                    spk_cnt_q <= '0;
                    sat_q     <= 1'b0;
                    if (enable) begin
                        // The spike on the starting edge is deliberately not counted
                        win_len_q <= window_len;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (win_end) begin
                        cyc_cnt_q <= '0;
                        spk_cnt_q <= '0;
                        sat_q     <= 1'b0;
                        if (enable) begin
                            win_len_q <= window_len;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (!enable) begin
                        // Partial window is discarded; the output register is untouched
                        state_q   <= ST_IDLE;
                        cyc_cnt_q <= '0;
                        spk_cnt_q <= '0;
                        sat_q     <= 1'b0;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 1'b1;
                        spk_cnt_q <= spk_cnt_nxt;
                        sat_q     <= sat_nxt;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Result register: load at window end, clear valid on handshake, flag lost results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
            saturated_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (win_end) begin
            rate_q       <= spk_cnt_nxt;
            saturated_q  <= sat_nxt;
            rate_valid_q <= 1'b1;
            // A handshake on the same edge means the old result was consumed, so nothing is lost
            if (rate_valid_q && !out_if.rate_ready) begin
                overrun_q <= 1'b1;
            end
        end else if (handshake) begin
            rate_valid_q <= 1'b0;
        end
    end

    assign out_if.rate       = rate_q;
    assign out_if.rate_valid = rate_valid_q;
    assign out_if.saturated  = saturated_q;
    assign out_if.overrun    = overrun_q;

`ifdef SPIKE_ISI_EN
    logic [COUNT_W-1:0] gap_q;
    logic [COUNT_W-1:0] gap_inc;
    logic [COUNT_W-1:0] isi_q;
    logic               seen_q;

    // Distance to the previous spike is the cycles elapsed since it plus this one, saturating
    assign gap_inc = (gap_q == CNT_MAX) ? CNT_MAX : gap_q + 1'b1;

    // Interval tracking runs across window boundaries and restarts only when RUN is entered from IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_q  <= '0;
            isi_q  <= '0;
            seen_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (enable) begin
                gap_q  <= '0;
                isi_q  <= '0;
                seen_q <= 1'b0;
            end
        end else begin
            if (spike) begin
                if (seen_q) begin
                    isi_q <= gap_inc;
                end
                gap_q  <= '0;
                seen_q <= 1'b1;
            end else begin
                gap_q <= gap_inc;
            end
        end
    end

    assign out_if.isi = isi_q;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: reset, windows, saturation, backpressure, abort, optional isi.
// Latency: inputs driven 1 time unit after each rising edge, outputs checked at the same point.
// Backpressure: rate_ready driven directly from the stimulus sequence.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       spike;
    logic [7:0] window_len;

    int total = 0;
    int bad   = 0;
    int exp2 [3] = '{2, 3, 2};

    always #5 clk = ~clk;

    spike_rate_decoder_if #(.COUNT_W(8)) bus ();

    spike_rate_decoder #(
        .WINDOW_W (8),
        .COUNT_W  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .spike      (spike),
        .window_len (window_len),
        .out_if     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        enable         = 1'b0;
        spike          = 1'b0;
        window_len     = 8'd0;
        bus.rate_ready = 1'b0;

        // Reset then idle
        tick();
        tick();
        chk("rst_rate", bus.rate, 0);
        chk("rst_valid", bus.rate_valid, 0);
        chk("rst_sat", bus.saturated, 0);
        chk("rst_ovr", bus.overrun, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            spike = ((i % 2) == 1);
            tick();
            chk("idle_rate", bus.rate, 0);
            chk("idle_valid", bus.rate_valid, 0);
            chk("idle_sat", bus.saturated, 0);
            chk("idle_ovr", bus.overrun, 0);
        end

        // Basic windows: 10 cycles, spike every 4th edge -> counts 2, 3, 2
        window_len     = 8'd9;
        enable         = 1'b1;
        bus.rate_ready = 1'b1;
        spike          = 1'b0;
        tick();
        chk("t2_start_valid", bus.rate_valid, 0);
        for (int k = 1; k <= 30; k++) begin
            spike = ((k % 4) == 0);
            tick();
            chk("t2_valid", bus.rate_valid, ((k % 10) == 0));
            chk("t2_ovr", bus.overrun, 0);
            if ((k % 10) == 0) chk("t2_rate", bus.rate, exp2[k/10-1]);
        end
        spike  = 1'b0;
        enable = 1'b0;
        tick();
        chk("t2_abort_valid", bus.rate_valid, 0);
        chk("t2_abort_rate", bus.rate, 2);

        // Saturation: 256 spikes clamp to 255, then an empty window
        window_len = 8'd255;
        spike      = 1'b1;
        enable     = 1'b1;
        tick();
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (k == 255) chk("t3_early_valid", bus.rate_valid, 0);
        end
        chk("t3_rate_max", bus.rate, 255);
        chk("t3_sat_set", bus.saturated, 1);
        chk("t3_valid", bus.rate_valid, 1);
        spike = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            if (k == 256) enable = 1'b0;
            tick();
            if (k == 1) begin
                chk("t3_hs_valid", bus.rate_valid, 0);
                chk("t3_sat_hold", bus.saturated, 1);
            end
        end
        chk("t3_rate_zero", bus.rate, 0);
        chk("t3_sat_clr", bus.saturated, 0);
        chk("t3_valid2", bus.rate_valid, 1);
        tick();
        chk("t3_consumed", bus.rate_valid, 0);

        // Backpressure: 5-cycle windows with counts 2, 5, 0
        bus.rate_ready = 1'b0;
        window_len     = 8'd4;
        enable         = 1'b1;
        spike          = 1'b0;
        tick();
        for (int k = 1; k <= 15; k++) begin
            spike          = (k <= 2) || (k >= 6 && k <= 10);
            bus.rate_ready = (k == 10);
            tick();
            if (k == 4) chk("t4_w1_pending", bus.rate_valid, 0);
            if (k == 5) begin
                chk("t4_w1_rate", bus.rate, 2);
                chk("t4_w1_valid", bus.rate_valid, 1);
                chk("t4_w1_ovr", bus.overrun, 0);
            end
            if (k == 7) begin
                chk("t4_hold_rate", bus.rate, 2);
                chk("t4_hold_valid", bus.rate_valid, 1);
            end
            if (k == 10) begin
                chk("t4_w2_rate", bus.rate, 5);
                chk("t4_w2_valid", bus.rate_valid, 1);
                chk("t4_w2_ovr", bus.overrun, 0);
            end
            if (k == 15) begin
                chk("t4_w3_rate", bus.rate, 0);
                chk("t4_w3_valid", bus.rate_valid, 1);
                chk("t4_w3_ovr", bus.overrun, 1);
            end
        end
        bus.rate_ready = 1'b1;
        enable         = 1'b0;
        spike          = 1'b0;
        tick();
        chk("t4_consumed", bus.rate_valid, 0);
        chk("t4_ovr_sticky", bus.overrun, 1);
        bus.rate_ready = 1'b0;
        repeat (5) tick();
        chk("t4_ovr_sticky2", bus.overrun, 1);

        // Mid-window abort: a 2-cycle window sets rate=2, then partial windows are dropped
        window_len = 8'd1;
        enable     = 1'b1;
        spike      = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        tick();
        chk("t5_pre_rate", bus.rate, 2);
        chk("t5_pre_valid", bus.rate_valid, 1);
        bus.rate_ready = 1'b1;
        tick();
        chk("t5_pre_consumed", bus.rate_valid, 0);
        window_len = 8'd15;
        enable     = 1'b1;
        tick();
        repeat (7) tick();
        enable = 1'b0;
        tick();
        chk("t5_abort_valid", bus.rate_valid, 0);
        chk("t5_abort_rate", bus.rate, 2);
        repeat (20) tick();
        chk("t5_idle_valid", bus.rate_valid, 0);
        chk("t5_idle_rate", bus.rate, 2);
        enable = 1'b1;
        tick();
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("t5_rst_rate", bus.rate, 0);
        chk("t5_rst_valid", bus.rate_valid, 0);
        chk("t5_rst_sat", bus.saturated, 0);
        chk("t5_rst_ovr", bus.overrun, 0);
        rst_n  = 1'b1;
        enable = 1'b0;
        repeat (20) tick();
        chk("t5_post_valid", bus.rate_valid, 0);
        chk("t5_post_rate", bus.rate, 0);

`ifdef SPIKE_ISI_EN
        // Inter-spike interval: spikes at RUN edges 2, 7, 10
        window_len = 8'd255;
        enable     = 1'b1;
        spike      = 1'b0;
        tick();
        chk("isi_start", bus.isi, 0);
        for (int k = 1; k <= 10; k++) begin
            spike = (k == 2) || (k == 7) || (k == 10);
            tick();
            if (k == 6)  chk("isi_first_only", bus.isi, 0);
            if (k == 7)  chk("isi_5", bus.isi, 5);
            if (k == 10) chk("isi_3", bus.isi, 3);
        end
        spike  = 1'b0;
        enable = 1'b0;
        tick();
        chk("isi_idle_hold", bus.isi, 3);
        enable = 1'b1;
        tick();
        chk("isi_reenter", bus.isi, 0);
        enable = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
